// File: rtl/handshake_protocol_monitor_if.sv
// Ready/valid bundle for N_CH independent channels; channel i payload is data[i*DATA_W +: DATA_W].
// The monitor attaches through the passive mon modport.
interface handshake_protocol_monitor_if #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 4
);
    logic [N_CH-1:0]        valid;
    logic [N_CH-1:0]        ready;
    logic [N_CH*DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
    modport mon    (input  valid, input  data, input  ready);
endinterface

// File: rtl/handshake_protocol_monitor.sv
// Passive ready/valid protocol monitor: valid-hold, data-stability and stall-timeout checks plus
// saturating transfer counters per channel. Optional SVA: HANDSHAKE_PROTOCOL_MONITOR_ASSERT_EN.
module handshake_protocol_monitor #(
    parameter int N_CH      = 3,
    parameter int DATA_W    = 4,
    parameter int STALL_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  logic                       CLK,
    input  logic                       ASYNCRESET,
    handshake_protocol_monitor_if.mon  bus,
    input  logic                       clear,
    output logic [N_CH*CNT_W-1:0]      xfer_count,
    output logic [N_CH-1:0]            err_valid_drop,
    output logic [N_CH-1:0]            err_data_chg,
    output logic [N_CH-1:0]            err_stall,
    output logic                       err_any,
    output logic [$clog2(N_CH):0]      first_err_ch,
    output logic                       err_pulse
);
    localparam int FE_W = $clog2(N_CH) + 1;
    localparam int ST_W = $clog2(STALL_MAX + 1);
    localparam logic [ST_W-1:0]  ST_MAX_V = ST_W'(STALL_MAX);
    localparam logic [ST_W-1:0]  ST_ONE   = ST_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [FE_W-1:0]  FE_NONE  = '1;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} pend_state_t;

    logic [N_CH-1:0] viol_vd, viol_dc, viol_st, viol_any;
    logic [N_CH-1:0] vd_reg, dc_reg, st_reg;
    logic [N_CH-1:0] vd_next, dc_next, st_next;
    logic [FE_W-1:0] first_reg, first_next;
    logic            pulse_reg, pulse_next;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        pend_state_t       state_reg, state_next;
        logic [DATA_W-1:0] hold_reg, hold_next;
        logic [ST_W-1:0]   stall_reg, stall_next, stall_calc;
        logic [CNT_W-1:0]  cnt_reg, cnt_next;
        logic              v, r, vd_l, dc_l, st_l;
        logic [DATA_W-1:0] d;

        assign v = bus.valid[gi];
        assign r = bus.ready[gi];
        assign d = bus.data[gi*DATA_W +: DATA_W];

        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET) begin
                state_reg <= ST_IDLE;
                hold_reg  <= '0;
                stall_reg <= '0;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                hold_reg  <= hold_next;
                stall_reg <= stall_next;
                cnt_reg   <= cnt_next;
            end
        end

        // The entry edge counts as the first stalled edge, so STALL_MAX stalled edges trip the flag.
        always_comb begin
            state_next = state_reg;
            hold_next  = hold_reg;
            stall_calc = '0;
            cnt_next   = cnt_reg;
            vd_l       = 1'b0;
            dc_l       = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (v && !r) begin
                        state_next = ST_WAIT;
                        hold_next  = d;
                        stall_calc = ST_ONE;
                    end
                end
                ST_WAIT: begin
                    if (!v) begin
                        state_next = ST_IDLE;
                        vd_l       = 1'b1;
                    end else begin
                        dc_l = (d != hold_reg);
                        if (r) begin
                            state_next = ST_IDLE;
                        end else begin
                            stall_calc = (stall_reg == ST_MAX_V) ? stall_reg : stall_reg + ST_ONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
            st_l = (stall_calc == ST_MAX_V);
            if (v && r && cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_ONE;
            end
            stall_next = stall_calc;
            if (clear) begin
                cnt_next   = '0;
                stall_next = '0;
            end
        end

        assign viol_vd[gi] = vd_l;
        assign viol_dc[gi] = dc_l;
        assign viol_st[gi] = st_l;
        assign xfer_count[gi*CNT_W +: CNT_W] = cnt_reg;

`ifdef HANDSHAKE_PROTOCOL_MONITOR_ASSERT_EN
        a_valid_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
            (state_reg == ST_WAIT) |-> v)
            else $error("handshake_protocol_monitor: valid dropped on channel %0d", gi);
        a_data_stable: assert property (@(posedge CLK) disable iff (ASYNCRESET)
            (state_reg == ST_WAIT && v) |-> (d == hold_reg))
            else $error("handshake_protocol_monitor: data changed on channel %0d", gi);
        a_stall: assert property (@(posedge CLK) disable iff (ASYNCRESET) !st_l)
            else $error("handshake_protocol_monitor: stall timeout on channel %0d", gi);
`else
        // Flags and counters only; no checker code is elaborated.
`endif
    end

    assign viol_any = viol_vd | viol_dc | viol_st;

    // Clear overrides any same-edge violation; the lowest violating channel wins the index.
    always_comb begin
        vd_next    = clear ? '0 : (vd_reg | viol_vd);
        dc_next    = clear ? '0 : (dc_reg | viol_dc);
        st_next    = clear ? '0 : (st_reg | viol_st);
        pulse_next = !clear && (|((viol_vd & ~vd_reg) | (viol_dc & ~dc_reg) | (viol_st & ~st_reg)));
        first_next = first_reg;
        if (clear) begin
            first_next = FE_NONE;
        end else if (first_reg == FE_NONE) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (viol_any[i]) first_next = FE_W'(i);
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            vd_reg    <= '0;
            dc_reg    <= '0;
            st_reg    <= '0;
            pulse_reg <= 1'b0;
            first_reg <= FE_NONE;
        end else begin
            vd_reg    <= vd_next;
            dc_reg    <= dc_next;
            st_reg    <= st_next;
            pulse_reg <= pulse_next;
            first_reg <= first_next;
        end
    end

    assign err_valid_drop = vd_reg;
    assign err_data_chg   = dc_reg;
    assign err_stall      = st_reg;
    assign err_any        = |{vd_reg, dc_reg, st_reg};
    assign first_err_ch   = first_reg;
    assign err_pulse      = pulse_reg;
endmodule
